// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM bundle for the LED pattern sequencer: s0 configuration slave and m0 write master.
// The slave modport is the sequencer's view; the master modport is the host/LED-block view.
interface led_pattern_sequencer_if;
  logic [3:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata;
  logic        avm_m0_address;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        avm_m0_waitrequest;

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata,
    output avm_m0_address, avm_m0_write, avm_m0_writedata,
    input  avm_m0_waitrequest
  );

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata,
    input  avm_m0_address, avm_m0_write, avm_m0_writedata,
    output avm_m0_waitrequest
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED sequencer: writes PAT[0..LENGTH-1] to the LED data register every PERIOD+1 cycles.
// Define LED_SEQ_IRQ_EN to add CTRL.IEN (bit2) and the registered level irq output.
module led_pattern_sequencer #(
  parameter int NUM_PATTERNS = 8,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic reset_n,
`ifdef LED_SEQ_IRQ_EN
  output logic irq,
`endif
  led_pattern_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_PATTERNS);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

  state_t           state_q, state_d;
  logic             run_q, loop_q;
  logic             done_q, done_d;
  logic [CNT_W-1:0] period_q, cnt_q, cnt_d, cnt_load;
  logic [3:0]       len_q, eff_len;
  logic [7:0]       pat_q [NUM_PATTERNS];
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic             wr_q, wr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             seq_start, seq_done, run_now, last;
  logic             ctrl_wr, status_wr, period_wr, len_wr, pat_sel, pat_wr;
  logic [31:0]      rdata;
`ifdef LED_SEQ_IRQ_EN
  logic             ien_q, ien_d;
`endif

  assign ctrl_wr   = bus.avs_s0_write && (bus.avs_s0_address == 4'd0);
  assign status_wr = bus.avs_s0_write && (bus.avs_s0_address == 4'd1);
  assign period_wr = bus.avs_s0_write && (bus.avs_s0_address == 4'd2);
  assign len_wr    = bus.avs_s0_write && (bus.avs_s0_address == 4'd3);
  assign pat_sel   = bus.avs_s0_address[3] && (int'(bus.avs_s0_address[2:0]) < NUM_PATTERNS);
  assign pat_wr    = bus.avs_s0_write && pat_sel;

  // A CTRL write in the current cycle is honoured immediately so a stop in WAIT lands next cycle.
  assign run_now  = ctrl_wr ? bus.avs_s0_writedata[0] : run_q;
  assign cnt_load = (period_q == '0) ? '0 : period_q - CNT_W'(1);

  always_comb begin
    eff_len = len_q;
    if (len_q == 4'd0)                         eff_len = 4'd1;
    else if (int'(len_q) > NUM_PATTERNS)       eff_len = 4'(NUM_PATTERNS);
  end

  assign last    = (4'(idx_q) >= eff_len - 4'd1);
  assign idx_nxt = last ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    seq_start = 1'b0;
    seq_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q) begin
          seq_start = 1'b1;
          idx_d     = '0;
          wr_d      = 1'b1;
          wdata_d   = pat_q[0];
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // The transfer always completes; a stop request only redirects where we go after it.
        if (!bus.avm_m0_waitrequest) begin
          wr_d    = 1'b0;
          cnt_d   = cnt_load;
          state_d = run_now ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (!run_now) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!last || loop_q) begin
          idx_d   = idx_nxt;
          wr_d    = 1'b1;
          wdata_d = pat_q[idx_nxt];
          state_d = WRITE;
        end else begin
          seq_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE set by the sequencer beats a same-cycle software clear.
  always_comb begin
    done_d = done_q;
    if ((status_wr && bus.avs_s0_writedata[1]) || seq_start) done_d = 1'b0;
    if (seq_done) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      period_q <= '0;
      len_q    <= 4'd1;
      for (int i = 0; i < NUM_PATTERNS; i++) pat_q[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        run_q  <= bus.avs_s0_writedata[0];
        loop_q <= bus.avs_s0_writedata[1];
      end
      if (seq_done)  run_q    <= 1'b0;
      if (period_wr) period_q <= bus.avs_s0_writedata[CNT_W-1:0];
      if (len_wr)    len_q    <= bus.avs_s0_writedata[3:0];
      if (pat_wr)    pat_q[bus.avs_s0_address[IW-1:0]] <= bus.avs_s0_writedata[7:0];
    end
  end

`ifdef LED_SEQ_IRQ_EN
  assign ien_d = ctrl_wr ? bus.avs_s0_writedata[2] : ien_q;

  // irq tracks the next DONE/IEN so a W1C drops it on the same edge that clears DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ien_q <= 1'b0;
      irq   <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq   <= done_d & ien_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (bus.avs_s0_read) begin
      case (bus.avs_s0_address)
        4'd0: begin
          rdata[0] = run_q;
          rdata[1] = loop_q;
`ifdef LED_SEQ_IRQ_EN
          rdata[2] = ien_q;
`endif
        end
        4'd1: begin
          rdata[0]   = (state_q != IDLE);
          rdata[1]   = done_q;
          rdata[6:4] = 3'(idx_q);
        end
        4'd2:    rdata[CNT_W-1:0] = period_q;
        4'd3:    rdata[3:0]       = len_q;
        default: if (pat_sel) rdata[7:0] = pat_q[bus.avs_s0_address[IW-1:0]];
      endcase
    end
  end

  assign bus.avs_s0_readdata  = rdata;
  assign bus.avm_m0_address   = 1'b0;
  assign bus.avm_m0_write     = wr_q;
  assign bus.avm_m0_writedata = {24'b0, wdata_q};
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus randomized one-shot runs
// compared against a table/arithmetic model of the expected LED write stream.
module tb_led_pattern_sequencer;
  localparam int N  = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  led_pattern_sequencer_if bus();
`ifdef LED_SEQ_IRQ_EN
  logic irq;
`endif

  led_pattern_sequencer #(.NUM_PATTERNS(N), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef LED_SEQ_IRQ_EN
    .irq     (irq),
`endif
    .bus     (bus)
  );

  int          n_tests, n_fail;
  int          cyc = 0;
  logic [31:0] acc_data[$];
  int          acc_cyc[$];
  int          acc_stall[$];
  int          cur_stalls, hold_viol, addr_viol, first_start;
  logic [31:0] held;
  int          bp_mode;
  logic [7:0]  mpat [N];
  logic [31:0] d;
  int          found, n_snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the m0 port mid-cycle: log accepted writes and any change of data while stalled.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.avm_m0_write === 1'b1) begin
      if (first_start < 0) first_start = cyc;
      if (cur_stalls > 0 && bus.avm_m0_writedata !== held) hold_viol++;
      if (bus.avm_m0_address !== 1'b0) addr_viol++;
      if (bus.avm_m0_waitrequest) begin
        held = bus.avm_m0_writedata;
        cur_stalls++;
      end else begin
        acc_data.push_back(bus.avm_m0_writedata);
        acc_cyc.push_back(cyc);
        acc_stall.push_back(cur_stalls);
        cur_stalls = 0;
      end
    end
  end

  initial begin
    bus.avm_m0_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.avm_m0_waitrequest = 1'b0;
        1:       bus.avm_m0_waitrequest = (acc_data.size() == 0) && (cur_stalls < 7);
        2:       bus.avm_m0_waitrequest = 1'b1;
        default: bus.avm_m0_waitrequest = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] v);
    wait_cycle();
    bus.avs_s0_address   = a;
    bus.avs_s0_writedata = v;
    bus.avs_s0_write     = 1'b1;
    wait_cycle();
    bus.avs_s0_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] v);
    wait_cycle();
    bus.avs_s0_address = a;
    bus.avs_s0_read    = 1'b1;
    @(negedge clk);
    v = bus.avs_s0_readdata;
    bus.avs_s0_read    = 1'b0;
  endtask

  task automatic prog_pat(input int i, input logic [7:0] v);
    mpat[i] = v;
    csr_write(4'(8 + i), {24'b0, v});
  endtask

  task automatic clear_mon();
    acc_data.delete();
    acc_cyc.delete();
    acc_stall.delete();
    cur_stalls  = 0;
    hold_viol   = 0;
    addr_viol   = 0;
    first_start = -1;
  endtask

  function automatic int eff_of(input int len);
    if (len < 1) return 1;
    if (len > N) return N;
    return len;
  endfunction

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int ok;
    ok = 0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3000; k++) begin
      csr_read(4'd1, s);
      if (!s[0]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq({tag, " idle timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_acc(input int n, input string tag);
    int ok;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (acc_data.size() >= n) begin
        ok = 1;
        break;
      end
      wait_cycle();
    end
    if (!ok) check_eq({tag, " accept timeout"}, 32'd1, 32'd0);
  endtask

  // Expected stream: entry i carries PAT[i mod eff]; accepts are max(PERIOD,1)+1 cycles apart plus stalls.
  task automatic check_run(input string tag, input int len, input int period, input int one_shot);
    int eff, gap;
    eff = eff_of(len);
    gap = ((period < 1) ? 1 : period) + 1;
    if (one_shot) check_eq({tag, " count"}, acc_data.size(), eff);
    for (int i = 0; i < acc_data.size(); i++) begin
      check_eq($sformatf("%s data%0d", tag, i), acc_data[i], {24'b0, mpat[i % eff]});
      if (i > 0)
        check_eq($sformatf("%s gap%0d", tag, i), acc_cyc[i] - acc_cyc[i-1], gap + acc_stall[i]);
    end
    check_eq({tag, " hold"}, hold_viol, 0);
    check_eq({tag, " m0 addr"}, addr_viol, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bp_mode = 0;
    clear_mon();
    reset_n              = 1'b0;
    bus.avs_s0_address   = '0;
    bus.avs_s0_read      = 1'b0;
    bus.avs_s0_write     = 1'b0;
    bus.avs_s0_writedata = '0;
    for (int i = 0; i < N; i++) mpat[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset values
    check_eq("rst m0_write", bus.avm_m0_write, 32'd0);
    check_eq("rst m0_data", bus.avm_m0_writedata, 32'd0);
    check_eq("rst m0_addr", bus.avm_m0_address, 32'd0);
    csr_read(4'd0, d); check_eq("rst ctrl", d, 32'd0);
    csr_read(4'd1, d); check_eq("rst status", d, 32'd0);
    csr_read(4'd2, d); check_eq("rst period", d, 32'd0);
    csr_read(4'd3, d); check_eq("rst length", d, 32'd1);
    for (int i = 0; i < N; i++) begin
      csr_read(4'(8 + i), d);
      check_eq($sformatf("rst pat%0d", i), d, 32'd0);
    end
    csr_read(4'd5, d); check_eq("unmapped read", d, 32'd0);

    // One-shot walking-one table, with a redundant RUN write mid-sequence
    clear_mon();
    prog_pat(0, 8'h01); prog_pat(1, 8'h02); prog_pat(2, 8'h04); prog_pat(3, 8'h08);
    csr_write(4'd3, 32'd4);
    csr_write(4'd2, 32'd5);
    csr_write(4'd0, 32'd1);
    wait_acc(2, "oneshot");
    csr_write(4'd0, 32'd1);
    wait_idle("oneshot");
    check_run("oneshot", 4, 5, 1);
    csr_read(4'd1, d); check_eq("oneshot status", d, 32'h32);
    csr_read(4'd0, d); check_eq("oneshot ctrl", d, 32'd0);
    csr_read(4'd2, d); check_eq("period readback", d, 32'd5);

    // Randomized one-shot runs, half with random backpressure
    for (int r = 0; r < 12; r++) begin
      int len, per;
      len = $urandom_range(0, 15);
      per = $urandom_range(0, 4);
      clear_mon();
      for (int i = 0; i < N; i++) prog_pat(i, 8'($urandom_range(0, 255)));
      csr_write(4'd3, len);
      csr_write(4'd2, per);
      bp_mode = (r % 2 == 1) ? 3 : 0;
      csr_write(4'd0, 32'd1);
      wait_idle($sformatf("rnd%0d", r));
      bp_mode = 0;
      check_run($sformatf("rnd%0d", r), len, per, 1);
      csr_read(4'd1, d);
      check_eq($sformatf("rnd%0d status", r), d, 32'h2 | ((eff_of(len) - 1) << 4));
    end

    // Loop two entries at the fastest rate, then stop during WAIT
    clear_mon();
    prog_pat(0, 8'hA5); prog_pat(1, 8'h5A);
    csr_write(4'd3, 32'd2);
    csr_write(4'd2, 32'd0);
    csr_write(4'd0, 32'd3);
    wait_acc(5, "loop");
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.avm_m0_write) begin
        found = 1;
        break;
      end
      wait_cycle();
    end
    check_eq("loop wait found", found, 32'd1);
    bus.avs_s0_address   = 4'd0;
    bus.avs_s0_writedata = 32'd0;
    bus.avs_s0_write     = 1'b1;
    wait_cycle();
    bus.avs_s0_write     = 1'b0;
    check_eq("loop stop m0_write", bus.avm_m0_write, 32'd0);
    n_snap = acc_data.size();
    csr_read(4'd1, d); check_eq("loop stop status", d & 32'h3, 32'd0);
    repeat (10) wait_cycle();
    check_eq("loop no more writes", acc_data.size(), n_snap);
    check_run("loop", 2, 0, 0);

    // Seven-cycle stall on the first transfer
    clear_mon();
    csr_write(4'd3, 32'd2);
    csr_write(4'd2, 32'd3);
    bp_mode = 1;
    csr_write(4'd0, 32'd1);
    wait_idle("bp");
    bp_mode = 0;
    check_eq("bp stalls", (acc_stall.size() > 0) ? acc_stall[0] : -1, 32'd7);
    check_eq("bp held cycles", (acc_cyc.size() > 0) ? acc_cyc[0] - first_start : -1, 32'd7);
    check_run("bp", 2, 3, 1);

    // Stop while a transfer is stalled
    clear_mon();
    csr_write(4'd3, 32'd3);
    csr_write(4'd2, 32'd1);
    bp_mode = 2;
    csr_write(4'd0, 32'd1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.avm_m0_write) begin
        found = 1;
        break;
      end
      wait_cycle();
    end
    check_eq("clrw write seen", found, 32'd1);
    csr_write(4'd0, 32'd0);
    repeat (3) wait_cycle();
    check_eq("clrw write held", bus.avm_m0_write, 32'd1);
    check_eq("clrw data held", bus.avm_m0_writedata, {24'b0, mpat[0]});
    csr_read(4'd1, d); check_eq("clrw busy", d[0], 32'd1);
    bp_mode = 0;
    repeat (20) wait_cycle();
    check_eq("clrw count", acc_data.size(), 32'd1);
    check_eq("clrw data", (acc_data.size() > 0) ? acc_data[0] : 32'hDEAD, {24'b0, mpat[0]});
    check_eq("clrw m0 idle", bus.avm_m0_write, 32'd0);
    csr_read(4'd1, d); check_eq("clrw not busy", d[0], 32'd0);

    // Reset during a stalled transfer
    clear_mon();
    csr_write(4'd3, 32'd1);
    bp_mode = 2;
    csr_write(4'd0, 32'd1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.avm_m0_write) begin
        found = 1;
        break;
      end
      wait_cycle();
    end
    check_eq("rstx write seen", found, 32'd1);
    reset_n = 1'b0;
    wait_cycle();
    check_eq("rstx m0_write", bus.avm_m0_write, 32'd0);
    check_eq("rstx m0_data", bus.avm_m0_writedata, 32'd0);
    reset_n = 1'b1;
    bp_mode = 0;
    csr_read(4'd0, d); check_eq("rstx ctrl", d, 32'd0);
    csr_read(4'd1, d); check_eq("rstx status", d, 32'd0);
    csr_read(4'd3, d); check_eq("rstx length", d, 32'd1);
    for (int i = 0; i < N; i++) mpat[i] = 8'h00;

`ifdef LED_SEQ_IRQ_EN
    check_eq("irq reset", irq, 32'd0);
    clear_mon();
    csr_write(4'd2, 32'd2);
    csr_write(4'd0, 32'd5);
    wait_idle("irq");
    check_eq("irq set", irq, 32'd1);
    csr_read(4'd0, d); check_eq("irq ctrl", d, 32'd4);
    csr_write(4'd1, 32'd2);
    check_eq("irq cleared", irq, 32'd0);
    csr_read(4'd1, d); check_eq("irq done cleared", d & 32'h2, 32'd0);
`else
    csr_write(4'd0, 32'd7);
    csr_read(4'd0, d); check_eq("ctrl bit2 ignored", d, 32'd3);
    csr_write(4'd0, 32'd0);
    wait_idle("ctrl7");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Avalon-MM controller that drives the LED register block autonomously: steps through a programmable table of 8-bit LED patterns at a programmable rate.
- Software configures it through an Avalon-MM slave (s0). An Avalon-MM write master (m0) issues pattern writes to the LED block's data register, offset 0.
- Sits between the HPS lightweight bridge and the LED block in the Qsys system.

Parameters:
- NUM_PATTERNS, 8, pattern table depth; power of 2, 2..8
- CNT_W, 32, width of the PERIOD register and step counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- avs_s0_address  in  4  slave word address
- avs_s0_read  in  1  slave read strobe
- avs_s0_write  in  1  slave write strobe
- avs_s0_readdata  out  32  slave read data (read latency 0, combinational)
- avs_s0_writedata  in  32  slave write data
- avm_m0_address  out  1  master address, constant 0 (LED data register)
- avm_m0_write  out  1  master write request
- avm_m0_writedata  out  32  master write data, {24'b0, pattern}
- avm_m0_waitrequest  in  1  master stall from the LED block

Behaviour:
- Clock and reset: one clock. reset_n is synchronous and active-low: all state resets on the clk edge where reset_n=0.
- Register map (word addresses):
  - 0 CTRL: bit0 RUN, bit1 LOOP; other bits read 0.
  - 1 STATUS, read-only except W1C: bit0 BUSY = state!=IDLE; bit1 DONE, sticky, write 1 clears; bits[6:4] current index.
  - 2 PERIOD: CNT_W bits, upper bits read 0.
  - 3 LENGTH: bits[3:0], number of table entries used; effective length = clamp(LENGTH, 1, NUM_PATTERNS).
  - 8..8+NUM_PATTERNS-1 PAT[i]: bits[7:0].
  - Unmapped addresses: reads return 0, writes are ignored.
- Reset values: CTRL=0, PERIOD=0, LENGTH=1, all PAT=0, DONE=0, index=0, state=IDLE, avm_m0_write=0, avm_m0_writedata=0.
- FSM states: IDLE, WRITE, WAIT.
- IDLE:
  - On the cycle after RUN becomes 1: index<=0, DONE<=0, go to WRITE.
  - Writing CTRL with RUN=1 while BUSY does not restart the sequence.
- WRITE:
  - avm_m0_write=1, writedata={24'b0, PAT[index]}, sampled at WRITE entry.
  - Data and write are held stable while waitrequest=1.
  - On the accept cycle (write & !waitrequest): counter <= max(PERIOD,1)-1, go to WAIT.
- WAIT:
  - avm_m0_write=0. If counter!=0, decrement.
  - If counter==0 and index < effective length-1: index++, go to WRITE.
  - Else if LOOP=1: index<=0, go to WRITE.
  - Else: DONE<=1, RUN<=0, go to IDLE.
- Step interval: accepted master writes are exactly max(PERIOD,1)+1 cycles apart when waitrequest stays low.
- RUN cleared by software:
  - In WAIT: go to IDLE next cycle, DONE unchanged.
  - In WRITE: the outstanding transfer completes first (Avalon rule), then IDLE.
- Writes during BUSY:
  - PAT writes take effect at the next WRITE entry.
  - PERIOD writes take effect at the next counter load.
  - LENGTH writes take effect at the next end-of-table compare.
- Simultaneous events: if software writes 1 to STATUS.DONE in the same cycle the FSM sets DONE, set wins.
- Reset mid-transfer: avm_m0_write deasserts on the reset edge; no completion is required.
- The LED block's state is not shadowed; the sequencer only writes, never reads m0.

Optional Feature:
- Macro: LED_SEQ_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and CTRL bit2 IEN (reset 0).
  - irq = DONE & IEN, registered, level-sensitive; cleared by the DONE W1C.
- Undefined:
  - No irq port.
  - CTRL bit2 is read-as-zero, write-ignored.

Test Plan:
- Reset: reset_n=0 for 2 cycles → all registers read reset values; avm_m0_write=0; STATUS=0.
- One-shot: PAT0..3=8'h01,02,04,08, LENGTH=4, PERIOD=5, CTRL=1 → four m0 writes with data 0x01,0x02,0x04,0x08, spaced 6 cycles; then STATUS.DONE=1, BUSY=0, CTRL.RUN=0.
- Loop and stop: LENGTH=2, LOOP=1, PERIOD=0 → writes alternate PAT0/PAT1 every 2 cycles. Write CTRL=0 during WAIT → IDLE next cycle, DONE=0.
- Backpressure: hold waitrequest=1 for 7 cycles on the first write → write and data held stable for 8 cycles; next write begins PERIOD+1 cycles after acceptance.
- Clear during WRITE: CTRL=0 while waitrequest=1 → write stays asserted until accepted, then IDLE; no further writes.
- IRQ (LED_SEQ_IRQ_EN): IEN=1, one-shot LENGTH=1 → irq=1 after completion; write STATUS=0x2 → irq=0 next cycle.
